// File: rtl/connect_mc_rr_pkg.sv
// Shared constants and helpers for the multi-client memory-channel interconnect.
package connect_mc_rr_pkg;

  // Arbitration mode selectors
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of an index able to address n entries (never narrower than 1 bit)
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/connect_mc_tag_fifo.sv
// Synchronous tag FIFO: records which slave port issued each in-flight request.
module connect_mc_tag_fifo
  import connect_mc_rr_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Tag storage
  always_ff @(posedge CLK) begin
    // NOTE: storage is not reset; entries are only read after being written.
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/connect_mc_rr.sv
// Merges CONNECT_NUM slave request channels onto one master channel with
// fixed-priority or round-robin arbitration and in-order response routing.
module connect_mc_rr
  import connect_mc_rr_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int CONNECT_NUM = 3,
  parameter int OUTSTANDING = 4,
  parameter int ARB_MODE    = ARB_FIXED
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_ADDR_VALID,
  input  logic [ADDR_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_ADDR,
  input  logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_DATA_VALID,
  input  logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_DATA,
  output logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_READY,
  output logic [CONNECT_NUM-1:0]            SLAVE_SEND_VALID,
  output logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_SEND_DATA,
  input  logic [CONNECT_NUM-1:0]            SLAVE_SEND_READY,
  output logic                              MASTER_SEND_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0]             MASTER_SEND_ADDR,
  output logic                              MASTER_SEND_DATA_VALID,
  output logic [DATA_WIDTH-1:0]             MASTER_SEND_DATA,
  input  logic                              MASTER_SEND_READY,
  input  logic                              MASTER_RECEIVE_VALID,
  input  logic [DATA_WIDTH-1:0]             MASTER_RECEIVE_DATA,
  output logic                              MASTER_RECEIVE_READY
);

  localparam int TW = idx_width(CONNECT_NUM);

  // Request register
  logic                  r_req_full;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_req_data;
  logic                  r_req_wr;
  logic [TW-1:0]         r_last_grant;
  // Response register
  logic                  r_rsp_full;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [TW-1:0]         r_rsp_port;

  logic [TW-1:0]         w_winner;
  logic                  w_any_valid;
  logic                  w_can_accept;
  logic                  w_req_fire;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_wr;
  logic                  w_rsp_slave_ready;
  logic                  w_rsp_fire;
  logic [TW-1:0]         w_tag_head;
  logic                  w_tag_full;
  logic                  w_tag_empty;

  // Arbiter: highest valid index, or first valid after the last grant
  always_comb begin : p_arb
    int v_idx;
    // NOTE: defaults first so no path through this block leaves a latch.
    w_winner    = '0;
    w_any_valid = 1'b0;
    v_idx       = 0;
    if (ARB_MODE == ARB_RR) begin
      for (int k = 1; k <= CONNECT_NUM; k++) begin
        v_idx = (int'(r_last_grant) + k) % CONNECT_NUM;
        if (!w_any_valid && SLAVE_RECEIVE_ADDR_VALID[v_idx]) begin
          w_winner    = TW'(v_idx);
          w_any_valid = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < CONNECT_NUM; i++) begin
        if (SLAVE_RECEIVE_ADDR_VALID[i]) begin
          w_winner    = TW'(i);
          w_any_valid = 1'b1;
        end
      end
    end
  end

  // The output register may be refilled as it drains; tag space is mandatory
  assign w_can_accept = (!r_req_full || MASTER_SEND_READY) && !w_tag_full;
  assign w_req_fire   = !RST && w_any_valid && w_can_accept;

  // One-hot grant and selection of the winning port's request fields
  always_comb begin
    SLAVE_RECEIVE_READY = '0;
    w_sel_addr          = '0;
    w_sel_data          = '0;
    w_sel_wr            = 1'b0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      if (TW'(i) == w_winner) begin
        SLAVE_RECEIVE_READY[i] = w_req_fire;
        w_sel_addr = SLAVE_RECEIVE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = SLAVE_RECEIVE_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_wr   = SLAVE_RECEIVE_DATA_VALID[i];
      end
    end
  end

  // Request register: load on grant, hold until the master accepts
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_req_full <= 1'b0;
      r_req_addr <= '0;
      r_req_data <= '0;
      r_req_wr   <= 1'b0;
    end else if (w_req_fire) begin
      r_req_full <= 1'b1;
      r_req_addr <= w_sel_addr;
      r_req_data <= w_sel_data;
      r_req_wr   <= w_sel_wr;
    end else if (MASTER_SEND_READY) begin
      r_req_full <= 1'b0;
    end
  end

  // Round-robin pointer moves only on an accepted request
  always_ff @(posedge CLK) begin
    if (RST)             r_last_grant <= TW'(CONNECT_NUM - 1);
    else if (w_req_fire) r_last_grant <= w_winner;
  end

  assign MASTER_SEND_ADDR_VALID = r_req_full;
  assign MASTER_SEND_ADDR       = r_req_addr;
  assign MASTER_SEND_DATA_VALID = r_req_full && r_req_wr;
  assign MASTER_SEND_DATA       = r_req_data;

  connect_mc_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_req_fire),
    .i_din   (w_winner),
    .i_pop   (w_rsp_fire),
    .o_head  (w_tag_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  // Route the response register to its target port
  always_comb begin
    w_rsp_slave_ready = 1'b0;
    SLAVE_SEND_VALID  = '0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      if (TW'(i) == r_rsp_port) begin
        w_rsp_slave_ready   = SLAVE_SEND_READY[i];
        SLAVE_SEND_VALID[i] = r_rsp_full;
      end
    end
  end

  assign MASTER_RECEIVE_READY = !RST && !w_tag_empty && (!r_rsp_full || w_rsp_slave_ready);
  assign w_rsp_fire           = MASTER_RECEIVE_VALID && MASTER_RECEIVE_READY;
  assign SLAVE_SEND_DATA      = {CONNECT_NUM{r_rsp_data}};

  // Response register: load with the popped tag, hold until the slave accepts
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rsp_full <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_port <= '0;
    end else if (w_rsp_fire) begin
      r_rsp_full <= 1'b1;
      r_rsp_data <= MASTER_RECEIVE_DATA;
      r_rsp_port <= w_tag_head;
    end else if (w_rsp_slave_ready) begin
      r_rsp_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_connect_mc_rr.sv
// Directed bench: a fixed-priority and a round-robin instance side by side.
module tb_connect_mc_rr;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 3;
  localparam int OS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Fixed-priority instance
  logic [N-1:0]    f_srav, f_srdv, f_srr, f_ssv, f_ssr;
  logic [AW*N-1:0] f_sra;
  logic [DW*N-1:0] f_srd, f_ssd;
  logic            f_msav, f_msdv, f_msr, f_mrv, f_mrr;
  logic [AW-1:0]   f_msa;
  logic [DW-1:0]   f_msd, f_mrd;
  // Round-robin instance
  logic [N-1:0]    r_srav, r_srdv, r_srr, r_ssv, r_ssr;
  logic [AW*N-1:0] r_sra;
  logic [DW*N-1:0] r_srd, r_ssd;
  logic            r_msav, r_msdv, r_msr, r_mrv, r_mrr;
  logic [AW-1:0]   r_msa;
  logic [DW-1:0]   r_msd, r_mrd;

  int n_pass   = 0;
  int n_checks = 0;

  connect_mc_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CONNECT_NUM(N),
                  .OUTSTANDING(OS), .ARB_MODE(0)) u_dut_fp (
    .CLK(clk), .RST(rst),
    .SLAVE_RECEIVE_ADDR_VALID(f_srav), .SLAVE_RECEIVE_ADDR(f_sra),
    .SLAVE_RECEIVE_DATA_VALID(f_srdv), .SLAVE_RECEIVE_DATA(f_srd),
    .SLAVE_RECEIVE_READY(f_srr), .SLAVE_SEND_VALID(f_ssv),
    .SLAVE_SEND_DATA(f_ssd), .SLAVE_SEND_READY(f_ssr),
    .MASTER_SEND_ADDR_VALID(f_msav), .MASTER_SEND_ADDR(f_msa),
    .MASTER_SEND_DATA_VALID(f_msdv), .MASTER_SEND_DATA(f_msd),
    .MASTER_SEND_READY(f_msr), .MASTER_RECEIVE_VALID(f_mrv),
    .MASTER_RECEIVE_DATA(f_mrd), .MASTER_RECEIVE_READY(f_mrr)
  );

  connect_mc_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CONNECT_NUM(N),
                  .OUTSTANDING(OS), .ARB_MODE(1)) u_dut_rr (
    .CLK(clk), .RST(rst),
    .SLAVE_RECEIVE_ADDR_VALID(r_srav), .SLAVE_RECEIVE_ADDR(r_sra),
    .SLAVE_RECEIVE_DATA_VALID(r_srdv), .SLAVE_RECEIVE_DATA(r_srd),
    .SLAVE_RECEIVE_READY(r_srr), .SLAVE_SEND_VALID(r_ssv),
    .SLAVE_SEND_DATA(r_ssd), .SLAVE_SEND_READY(r_ssr),
    .MASTER_SEND_ADDR_VALID(r_msav), .MASTER_SEND_ADDR(r_msa),
    .MASTER_SEND_DATA_VALID(r_msdv), .MASTER_SEND_DATA(r_msd),
    .MASTER_SEND_READY(r_msr), .MASTER_RECEIVE_VALID(r_mrv),
    .MASTER_RECEIVE_DATA(r_mrd), .MASTER_RECEIVE_READY(r_mrr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; outputs are sampled 2 time units later
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [N-1:0] rr_exp [6];
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // ---------------- Reset with every input active ----------------
    rst    = 1'b1;
    f_srav = '1; f_srdv = '1; f_ssr = '1; f_msr = 1'b1; f_mrv = 1'b1;
    f_sra  = '1; f_srd  = '1; f_mrd = '1;
    r_srav = '1; r_srdv = '1; r_ssr = '1; r_msr = 1'b1; r_mrv = 1'b1;
    r_sra  = '1; r_srd  = '1; r_mrd = '1;
    step();
    check("rst_f_srr",  f_srr,  3'b000);
    check("rst_f_msav", f_msav, 1'b0);
    check("rst_f_mrr",  f_mrr,  1'b0);
    check("rst_f_ssv",  f_ssv,  3'b000);
    check("rst_f_msa",  f_msa,  32'h0);
    check("rst_f_ssd",  f_ssd[DW-1:0], 32'h0);
    check("rst_r_srr",  r_srr,  3'b000);
    check("rst_r_msav", r_msav, 1'b0);
    rst    = 1'b0;
    f_srav = '0; r_srav = '0;
    #1;
    check("post_rst_f_srr",  f_srr,  3'b000);
    check("post_rst_f_msav", f_msav, 1'b0);
    check("post_rst_f_mrr",  f_mrr,  1'b0);
    check("post_rst_f_ssv",  f_ssv,  3'b000);
    check("post_rst_r_mrr",  r_mrr,  1'b0);
    f_mrv = 1'b0; r_mrv = 1'b0;
    step();

    // ---------------- Fixed priority: 2, then 1, then 0 ----------------
    f_sra  = {32'h30, 32'h20, 32'h10};
    f_srd  = {32'hA2, 32'hA1, 32'hA0};
    f_srdv = 3'b101;
    f_srav = 3'b111;
    #1;
    check("fp_grant0", f_srr, 3'b100);
    step();
    f_srav = 3'b011;
    #1;
    check("fp_msav0", f_msav, 1'b1);
    check("fp_msa0",  f_msa,  32'h30);
    check("fp_msd0",  f_msd,  32'hA2);
    check("fp_msdv0", f_msdv, 1'b1);
    check("fp_grant1", f_srr, 3'b010);
    step();
    f_srav = 3'b001;
    #1;
    check("fp_msa1",  f_msa,  32'h20);
    check("fp_msdv1", f_msdv, 1'b0);
    check("fp_grant2", f_srr, 3'b001);
    step();
    f_srav = 3'b000;
    #1;
    check("fp_msa2", f_msa, 32'h10);
    step();
    check("fp_msav_idle", f_msav, 1'b0);
    // Master echoes each request's data back in order
    f_mrv = 1'b1; f_mrd = 32'hA2;
    #1;
    check("fp_mrr", f_mrr, 1'b1);
    step();
    check("fp_rsp0_v", f_ssv, 3'b100);
    check("fp_rsp0_d", f_ssd[DW*3-1 -: DW], 32'hA2);
    f_mrd = 32'hA1;
    step();
    check("fp_rsp1_v", f_ssv, 3'b010);
    check("fp_rsp1_d", f_ssd[DW*2-1 -: DW], 32'hA1);
    f_mrd = 32'hA0;
    step();
    check("fp_rsp2_v", f_ssv, 3'b001);
    check("fp_rsp2_d", f_ssd[DW-1:0], 32'hA0);
    f_mrv = 1'b0;
    step();
    check("fp_rsp_idle", f_ssv, 3'b000);
    check("fp_mrr_empty", f_mrr, 1'b0);

    // ---------------- Round-robin: 0,1,2,0,1,2 ----------------
    r_srav = 3'b111; r_mrv = 1'b1; r_mrd = 32'hC0DE;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_grant%0d", k), r_srr, rr_exp[k]);
      if (k == 2) check("rr_rsp_port0", r_ssv, 3'b001);
      step();
    end
    r_srav = 3'b000;
    step();
    r_mrv = 1'b0;
    step();
    check("rr_drained", r_mrr, 1'b0);

    // ---------------- Outstanding limit ----------------
    f_sra[AW-1:0] = 32'h100;
    f_srav = 3'b001;
    for (int k = 0; k < OS; k++) begin
      #1;
      check($sformatf("os_accept%0d", k), f_srr, 3'b001);
      step();
    end
    #1;
    check("os_full0", f_srr, 3'b000);
    step();
    check("os_full1", f_srr, 3'b000);
    f_mrv = 1'b1; f_mrd = 32'h55;
    #1;
    check("os_mrr", f_mrr, 1'b1);
    check("os_full_pop", f_srr, 3'b000);
    step();
    f_mrv = 1'b0;
    #1;
    check("os_fifth", f_srr, 3'b001);
    check("os_rsp_v", f_ssv, 3'b001);
    step();
    f_srav = 3'b000;
    f_mrv  = 1'b1;
    repeat (OS) step();
    f_mrv = 1'b0;
    #1;
    check("os_drained", f_mrr, 1'b0);
    step();

    // ---------------- Response backpressure ----------------
    f_srav = 3'b011;
    step();
    f_srav = 3'b001;
    step();
    f_srav = 3'b000;
    f_ssr  = 3'b101;
    f_mrv  = 1'b1; f_mrd = 32'hDEADBEEF;
    step();
    f_mrd = 32'h12345678;
    #1;
    check("bp_v0", f_ssv, 3'b010);
    check("bp_mrr0", f_mrr, 1'b0);
    step();
    check("bp_v1", f_ssv, 3'b010);
    check("bp_d1", f_ssd[DW*2-1 -: DW], 32'hDEADBEEF);
    check("bp_mrr1", f_mrr, 1'b0);
    f_ssr = 3'b111;
    #1;
    check("bp_mrr_rel", f_mrr, 1'b1);
    step();
    f_mrv = 1'b0;
    #1;
    check("bp_next_v", f_ssv, 3'b001);
    check("bp_next_d", f_ssd[DW-1:0], 32'h12345678);
    step();
    check("bp_idle", f_ssv, 3'b000);

    // ---------------- Reset mid-operation ----------------
    f_srav = 3'b111;
    repeat (3) step();
    f_srav = 3'b000;
    #1;
    check("mr_inflight", f_mrr, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mr_msav", f_msav, 1'b0);
    check("mr_mrr",  f_mrr,  1'b0);
    check("mr_ssv",  f_ssv,  3'b000);
    f_sra[AW*2-1 -: AW] = 32'h44;
    f_srav = 3'b010;
    #1;
    check("mr_grant", f_srr, 3'b010);
    step();
    f_srav = 3'b000;
    f_mrv  = 1'b1; f_mrd = 32'h77;
    #1;
    check("mr_msa", f_msa, 32'h44);
    check("mr_mrr_one", f_mrr, 1'b1);
    step();
    f_mrv = 1'b0;
    #1;
    check("mr_rsp_v", f_ssv, 3'b010);
    check("mr_rsp_d", f_ssd[DW*2-1 -: DW], 32'h77);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
